// File: rtl/atm_pkg.sv
// Shared state encoding and default configuration for the ATM session controller.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PIN   = 3'd1,
        ST_MENU  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_WDRAW = 3'd4,
        ST_LOCK  = 3'd5
    } state_e;

    localparam logic [4:0]  CARD_ID_DEF   = 5'b11111;
    localparam logic [3:0]  PIN_REF_DEF   = 4'b1001;
    localparam logic [3:0]  INIT_BAL_DEF  = 4'd12;
    localparam int unsigned MAX_TRIES_DEF = 3;
    localparam logic [8:0]  TIMEOUT_DEF   = 9'd300;

    // States in which the inactivity countdown runs.
    function automatic logic is_active(input state_e s);
        return (s == ST_PIN) || (s == ST_MENU) || (s == ST_SHOW) || (s == ST_WDRAW);
    endfunction

endpackage

// File: rtl/atm_timeout_cnt.sv
// Inactivity down-counter: clear beats load beats decrement; stops at zero.
module atm_timeout_cnt #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN login, balance display, withdrawal,
// lockout after repeated wrong PINs, and inactivity timeout.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter logic [4:0]  CARD_ID   = CARD_ID_DEF,
    parameter logic [3:0]  PIN_REF   = PIN_REF_DEF,
    parameter logic [3:0]  INIT_BAL  = INIT_BAL_DEF,
    parameter int unsigned MAX_TRIES = MAX_TRIES_DEF,
    parameter logic [8:0]  TIMEOUT   = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] cod,
    input  logic [3:0] pin,
    input  logic [3:0] val,
    input  logic       enter,
    input  logic       sel_op,
    input  logic       cancel,
    output logic [2:0] state,
    output logic [3:0] saldo,
    output logic [8:0] tempo,
    output logic       dispense,
    output logic       err,
    output logic       locked
);

    localparam int unsigned TRIES_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    state_e               state_q, state_d;
    logic [TRIES_W-1:0]   tries_q, tries_d;
    logic [3:0]           bal_q, bal_d;
    logic                 err_q, err_d;
    logic                 disp_q, disp_d;
    logic                 enter_q;
    logic                 enter_rise;
    logic                 reload;
    logic                 tmo_zero;
    logic                 cnt_clr, cnt_load;

    assign enter_rise = enter & ~enter_q;

    // Event priority: cancel, then timeout, then enter edge; LOCK ignores all.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        bal_d   = bal_q;
        err_d   = 1'b0;
        disp_d  = 1'b0;
        reload  = 1'b0;
        if (state_q == ST_LOCK) begin
            state_d = ST_LOCK;
        end else if (cancel) begin
            state_d = ST_IDLE;
        end else if (is_active(state_q) && tmo_zero) begin
            state_d = ST_IDLE;
        end else if (enter_rise) begin
            reload = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (cod == CARD_ID) begin
                        state_d = ST_PIN;
                        tries_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_PIN: begin
                    err_d = (pin != PIN_REF);
                    if (pin == PIN_REF) begin
                        state_d = ST_MENU;
                        tries_d = '0;
                    end else if (tries_q >= LAST_TRY) begin
                        state_d = ST_LOCK;
                    end else begin
                        tries_d = tries_q + TRIES_W'(1);
                    end
                end
                ST_MENU:  state_d = sel_op ? ST_WDRAW : ST_SHOW;
                ST_SHOW:  state_d = ST_MENU;
                ST_WDRAW: begin
                    if ((val != '0) && (val <= bal_q)) begin
                        bal_d   = bal_q - val;
                        disp_d  = 1'b1;
                        state_d = ST_MENU;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) tries_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tries_q <= '0;
            bal_q   <= INIT_BAL;
            err_q   <= 1'b0;
            disp_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            bal_q   <= bal_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
            enter_q <= enter;
        end
    end

    assign cnt_clr  = !is_active(state_d);
    assign cnt_load = reload || (state_d != state_q);

    atm_timeout_cnt #(
        .W (9)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (TIMEOUT),
        .en       (is_active(state_q)),
        .cnt      (tempo),
        .zero     (tmo_zero)
    );

    assign state    = state_q;
    assign saldo    = ((state_q == ST_SHOW) || (state_q == ST_WDRAW)) ? bal_q : '0;
    assign dispense = disp_q;
    assign err      = err_q;
    assign locked   = (state_q == ST_LOCK);

endmodule
